// File: rtl/hazard_lights_n.sv
// rtl/hazard_lights_n.sv - WIDTH-bit hazard/wind LED bar with prescaled pattern steps.
// Optional macro HAZARD_BOUNCE_EN enables the BOUNCE pattern on mode 11 (otherwise 11 acts as CALM).
module hazard_lights_n #(
  parameter int WIDTH = 10,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] leds,
  output logic             step
);

  typedef enum logic [1:0] {
    CALM       = 2'b00,
    SWEEP_UP   = 2'b01,
    SWEEP_DOWN = 2'b10,
    BOUNCE     = 2'b11
  } mode_t;

  localparam logic [4:0]       HALF = 5'((WIDTH - 1) / 2);
  localparam logic [23:0]      LAST = 24'(DIV - 1);
  localparam logic [WIDTH-1:0] LSB  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MSB  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [23:0] cnt;
  logic [4:0]  pos;
  mode_t       cur_mode;
  mode_t       req;
  logic        tick;
`ifdef HAZARD_BOUNCE_EN
  logic        dir_up;
`endif

  // Mirrored pair converging on the centre: bit p and bit WIDTH-1-p.
  function automatic logic [WIDTH-1:0] calm_pat(input logic [4:0] p);
    return (LSB << p) | (MSB >> p);
  endfunction

  function automatic logic [WIDTH-1:0] start_pat(input mode_t m);
    case (m)
      SWEEP_UP:   return LSB;
      SWEEP_DOWN: return MSB;
      BOUNCE:     return LSB;
      default:    return calm_pat(5'd0);
    endcase
  endfunction

  always_comb begin
    tick = (cnt == LAST);
    req  = mode_t'(mode);
`ifndef HAZARD_BOUNCE_EN
    // Without bounce support, 11 is an alias of CALM, including for restart detection.
    if (mode == 2'b11) req = CALM;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      leds     <= calm_pat(5'd0);
      step     <= 1'b0;
      cur_mode <= CALM;
      pos      <= '0;
`ifdef HAZARD_BOUNCE_EN
      dir_up   <= 1'b1;
`endif
    end else begin
      step <= tick;
      cnt  <= tick ? '0 : cnt + 24'd1;
      if (tick) begin
        if (req != cur_mode) begin
          cur_mode <= req;
          leds     <= start_pat(req);
          pos      <= '0;
`ifdef HAZARD_BOUNCE_EN
          dir_up   <= 1'b1;
`endif
        end else begin
          case (cur_mode)
            CALM: begin
              if (pos == HALF) begin
                pos  <= '0;
                leds <= calm_pat(5'd0);
              end else begin
                pos  <= pos + 5'd1;
                leds <= calm_pat(pos + 5'd1);
              end
            end
            SWEEP_UP:   leds <= {leds[WIDTH-2:0], leds[WIDTH-1]};
            SWEEP_DOWN: leds <= {leds[0], leds[WIDTH-1:1]};
`ifdef HAZARD_BOUNCE_EN
            BOUNCE: begin
              // Turn around at the ends so neither endpoint is shown twice in a row.
              if (dir_up) begin
                if (leds[WIDTH-1]) begin
                  dir_up <= 1'b0;
                  leds   <= MSB >> 1;
                end else begin
                  leds   <= leds << 1;
                end
              end else begin
                if (leds[0]) begin
                  dir_up <= 1'b1;
                  leds   <= LSB << 1;
                end else begin
                  leds   <= leds >> 1;
                end
              end
            end
`endif
            default: leds <= leds;
          endcase
        end
      end
    end
  end

endmodule
